// File: rtl/rx_freq_sched_pkg.sv
// Shared types and constants for the RX DDC frequency-update scheduler.
// Optional feature macro used by the top: RX_FREQ_SCHED_STATS_EN.
package rx_freq_sched_pkg;

   localparam int unsigned CHAN_W       = 4;   // request channel field width
   localparam int unsigned TOS_W        = 32;  // receiver config data bus width
   localparam int unsigned FREQ_L_W     = 32;  // low word is work[31:0]
   localparam int unsigned FREQ_H_LSB   = 32;  // high word is work[FW-1:32]
   localparam int unsigned SYNC_GAP_MIN = 1;
   localparam int unsigned SYNC_GAP_MAX = 7;
   localparam int unsigned GAP_CNT_W    = 3;
   localparam int unsigned STAT_W       = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHAN  = 3'd1,
      S_FRZ_H = 3'd2,
      S_GAP_H = 3'd3,
      S_WR_H  = 3'd4,
      S_FRZ_L = 3'd5,
      S_GAP_L = 3'd6,
      S_WR_L  = 3'd7
   } state_e;

   // Clamp the sync gap into the supported range and return the down-counter preload.
   function automatic logic [GAP_CNT_W-1:0] gap_load(input int unsigned gap);
      int unsigned g;
      g = (gap < SYNC_GAP_MIN) ? SYNC_GAP_MIN : ((gap > SYNC_GAP_MAX) ? SYNC_GAP_MAX : gap);
      return GAP_CNT_W'(g - 1);
   endfunction

endpackage

// File: rtl/rx_freq_sched_rr_pick.sv
// Round-robin priority picker: first set mask bit at or after ptr, wrapping.
module rr_pick #(
   parameter  int unsigned N  = 8,
   localparam int unsigned PW = $clog2(N)
) (
   input  logic [N-1:0]  mask,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [PW-1:0] index,
   output logic          any
);

   // Scan N positions starting at ptr; the first hit wins.
   always_comb begin : scan
      logic [PW:0] k;
      onehot = '0;
      index  = '0;
      any    = 1'b0;
      k      = '0;
      for (int unsigned i = 0; i < N; i++) begin
         k = (PW+1)'(ptr) + (PW+1)'(i);
         if (k >= (PW+1)'(N)) k = k - (PW+1)'(N);
         if (!any && mask[k[PW-1:0]]) begin
            any                  = 1'b1;
            index                = k[PW-1:0];
            onehot[k[PW-1:0]]    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rx_freq_sched.sv
// Per-channel RX DDC frequency-update scheduler: coalesces tuning words into
// per-channel slots and issues SET_RX_CHAN / FREEZE / FREQ_H / FREEZE / FREQ_L
// sequences round-robin with a settle gap after each freeze.
// Optional macro RX_FREQ_SCHED_STATS_EN adds coalesce_cnt and issue_cnt ports.
module rx_freq_sched
   import rx_freq_sched_pkg::*;
#(
   parameter int unsigned NCHAN    = 8,
   parameter int unsigned SYNC_GAP = 2,
   parameter int unsigned FW       = 48
) (
   input  logic              cpu_clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [CHAN_W-1:0] req_chan,
   input  logic [FW-1:0]     req_freq,
   output logic              req_ready,
   output logic              req_err,
   output logic [TOS_W-1:0]  tos_out,
   output logic              set_chan_wr,
   output logic              freeze_wr,
   output logic              freqH_wr,
   output logic              freqL_wr,
   output logic              busy,
   output logic [NCHAN-1:0]  pending
`ifdef RX_FREQ_SCHED_STATS_EN
   ,
   output logic [STAT_W-1:0] coalesce_cnt,
   output logic [STAT_W-1:0] issue_cnt
`endif
);

   localparam int unsigned CW = $clog2(NCHAN);
   localparam logic [GAP_CNT_W-1:0] GAP_LOAD = gap_load(SYNC_GAP);

   logic [FW-1:0]        slot [NCHAN];
   logic [FW-1:0]        work;
   state_e               state;
   logic [GAP_CNT_W-1:0] gap_cnt;
   logic [CW-1:0]        rr_ptr;

   logic [NCHAN-1:0]     pick_onehot;
   logic [CW-1:0]        pick_idx;
   logic                 pick_any;

   logic                 accept;
   logic                 grant;
   logic [NCHAN-1:0]     req_onehot;

   // Slots always accept while out of reset; an overwrite is the coalesce.
   assign req_ready  = !rst;
   assign accept     = req_valid && ({1'b0, req_chan} < (CHAN_W+1)'(NCHAN));
   assign grant      = (state == S_IDLE) && pick_any;
   assign req_onehot = accept ? (NCHAN'(1) << req_chan[CW-1:0]) : '0;

   rr_pick #(.N(NCHAN)) u_pick (
      .mask   (pending),
      .ptr    (rr_ptr),
      .onehot (pick_onehot),
      .index  (pick_idx),
      .any    (pick_any)
   );

   // Slot storage; contents are only meaningful while the pending bit is set.
   always_ff @(posedge cpu_clk) begin
      if (accept) slot[req_chan[CW-1:0]] <= req_freq;
   end

   // Pending mask: a same-cycle request re-arms the bit the grant is clearing.
   always_ff @(posedge cpu_clk) begin
      if (rst) pending <= '0;
      else     pending <= (pending & ~(grant ? pick_onehot : '0)) | req_onehot;
   end

   // Out-of-range channel requests are dropped and flagged for one cycle.
   always_ff @(posedge cpu_clk) begin
      if (rst) req_err <= 1'b0;
      else     req_err <= req_valid && !accept;
   end

   // Sequencer: strobes are registered together with the state they belong to.
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         state       <= S_IDLE;
         work        <= '0;
         gap_cnt     <= '0;
         rr_ptr      <= '0;
         tos_out     <= '0;
         set_chan_wr <= 1'b0;
         freeze_wr   <= 1'b0;
         freqH_wr    <= 1'b0;
         freqL_wr    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         set_chan_wr <= 1'b0;
         freeze_wr   <= 1'b0;
         freqH_wr    <= 1'b0;
         freqL_wr    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant) begin
                  work        <= slot[pick_idx];
                  rr_ptr      <= (pick_idx == CW'(NCHAN - 1)) ? '0 : pick_idx + CW'(1);
                  tos_out     <= TOS_W'(pick_idx);
                  set_chan_wr <= 1'b1;
                  busy        <= 1'b1;
                  state       <= S_CHAN;
               end
            end
            S_CHAN: begin
               tos_out   <= TOS_W'(work[FW-1:FREQ_H_LSB]);
               freeze_wr <= 1'b1;
               state     <= S_FRZ_H;
            end
            S_FRZ_H: begin
               gap_cnt <= GAP_LOAD;
               state   <= S_GAP_H;
            end
            S_GAP_H: begin
               if (gap_cnt == '0) begin
                  freqH_wr <= 1'b1;
                  state    <= S_WR_H;
               end else begin
                  gap_cnt <= gap_cnt - GAP_CNT_W'(1);
               end
            end
            S_WR_H: begin
               tos_out   <= work[FREQ_L_W-1:0];
               freeze_wr <= 1'b1;
               state     <= S_FRZ_L;
            end
            S_FRZ_L: begin
               gap_cnt <= GAP_LOAD;
               state   <= S_GAP_L;
            end
            S_GAP_L: begin
               if (gap_cnt == '0) begin
                  freqL_wr <= 1'b1;
                  state    <= S_WR_L;
               end else begin
                  gap_cnt <= gap_cnt - GAP_CNT_W'(1);
               end
            end
            S_WR_L: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef RX_FREQ_SCHED_STATS_EN
   // Coalesce count saturates; issue count wraps once per completed sequence.
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         coalesce_cnt <= '0;
         issue_cnt    <= '0;
      end else begin
         if (accept && pending[req_chan[CW-1:0]] && (coalesce_cnt != '1))
            coalesce_cnt <= coalesce_cnt + STAT_W'(1);
         if (state == S_WR_L)
            issue_cnt <= issue_cnt + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_rx_freq_sched.sv
// Self-checking bench for rx_freq_sched (default NCHAN=8, SYNC_GAP=2, FW=48).
// Checks stats ports too when RX_FREQ_SCHED_STATS_EN is defined.
module tb_rx_freq_sched;

   localparam int NCHAN = 8;
   localparam int G     = 2;
   localparam int LEN   = 6 + 2 * G;   // grant-to-next-grant spacing

   logic        cpu_clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [3:0]  req_chan;
   logic [47:0] req_freq;
   logic        req_ready, req_err, set_chan_wr, freeze_wr, freqH_wr, freqL_wr, busy;
   logic [31:0] tos_out;
   logic [NCHAN-1:0] pending;
`ifdef RX_FREQ_SCHED_STATS_EN
   logic [15:0] coalesce_cnt, issue_cnt;
`endif

   rx_freq_sched #(.NCHAN(NCHAN), .SYNC_GAP(G), .FW(48)) dut (
      .cpu_clk     (cpu_clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_chan    (req_chan),
      .req_freq    (req_freq),
      .req_ready   (req_ready),
      .req_err     (req_err),
      .tos_out     (tos_out),
      .set_chan_wr (set_chan_wr),
      .freeze_wr   (freeze_wr),
      .freqH_wr    (freqH_wr),
      .freqL_wr    (freqL_wr),
      .busy        (busy),
      .pending     (pending)
`ifdef RX_FREQ_SCHED_STATS_EN
      ,
      .coalesce_cnt(coalesce_cnt),
      .issue_cnt   (issue_cnt)
`endif
   );

   always #5 cpu_clk = ~cpu_clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Transaction-level reference: pending set, stored words, rr pointer, current issue.
   bit          armed = 1'b0;
   bit          mp [NCHAN];
   logic [47:0] ms [NCHAN];
   int          m_ptr, m_gc, m_chan;
   bit          m_act, m_err;
   logic [47:0] m_word;
   logic [31:0] m_tos;
   logic [15:0] m_coal, m_issue;

   // Observed issues, captured from the bus.
   typedef struct { int chan; logic [31:0] h; logic [31:0] l; int at; } issue_t;
   issue_t issued [$];
   int     cap_chan, cap_at;
   logic [31:0] cap_h;

   // Last sampled outputs for directed checks.
   logic s_chan, s_frz, s_h, s_l, s_busy, s_err;
   logic [31:0] s_tos;
   logic [NCHAN-1:0] s_pend;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Sample DUT, compare against the reference, then advance the reference one cycle.
   task automatic cycle_check(input logic r, input logic v, input logic [3:0] c, input logic [47:0] f);
      int d;
      bit in_seq, any;
      logic [NCHAN-1:0] epend;
      bit hit;
      s_chan = set_chan_wr; s_frz = freeze_wr; s_h = freqH_wr; s_l = freqL_wr;
      s_busy = busy; s_err = req_err; s_tos = tos_out; s_pend = pending;
      d      = cyc - m_gc;
      in_seq = m_act && d >= 1 && d < LEN;
      if (armed) begin
         if (in_seq && d == 1)     m_tos = 32'(m_chan);
         if (in_seq && d == 2)     m_tos = 32'(m_word[47:32]);
         if (in_seq && d == 4 + G) m_tos = m_word[31:0];
         for (int i = 0; i < NCHAN; i++) epend[i] = mp[i];
         chk("set_chan_wr", 64'(s_chan), 64'(in_seq && d == 1));
         chk("freeze_wr",   64'(s_frz),  64'(in_seq && (d == 2 || d == 4 + G)));
         chk("freqH_wr",    64'(s_h),    64'(in_seq && d == 3 + G));
         chk("freqL_wr",    64'(s_l),    64'(in_seq && d == 5 + 2 * G));
         chk("busy",        64'(s_busy), 64'(in_seq));
         chk("tos_out",     64'(s_tos),  64'(m_tos));
         chk("pending",     64'(s_pend), 64'(epend));
         chk("req_err",     64'(s_err),  64'(m_err));
         chk("req_ready",   64'(req_ready), 64'(!r));
`ifdef RX_FREQ_SCHED_STATS_EN
         chk("coalesce_cnt", 64'(coalesce_cnt), 64'(m_coal));
         chk("issue_cnt",    64'(issue_cnt),    64'(m_issue));
`endif
      end
      if (s_chan === 1'b1) begin cap_chan = int'(s_tos); cap_at = cyc; end
      if (s_h === 1'b1) cap_h = s_tos;
      if (s_l === 1'b1) issued.push_back('{cap_chan, cap_h, s_tos, cap_at});
      if (r) begin
         foreach (mp[i]) mp[i] = 1'b0;
         m_ptr = 0; m_act = 1'b0; m_err = 1'b0; m_tos = '0; m_coal = '0; m_issue = '0;
         m_gc = 0; armed = 1'b1;
      end else begin
         hit = (v && c < NCHAN) ? mp[c] : 1'b0;
         if (in_seq && d == 5 + 2 * G) m_issue = m_issue + 16'd1;
         any = 1'b0;
         foreach (mp[i]) any |= mp[i];
         if ((!m_act || d >= LEN) && any) begin
            for (int i = 0; i < NCHAN; i++) begin
               int k;
               k = (m_ptr + i) % NCHAN;
               if (mp[k]) begin
                  m_act = 1'b1; m_gc = cyc; m_chan = k; m_word = ms[k];
                  mp[k] = 1'b0; m_ptr = (k + 1) % NCHAN;
                  break;
               end
            end
         end
         if (v && c < NCHAN) begin
            if (hit && m_coal != 16'hFFFF) m_coal = m_coal + 16'd1;
            ms[c] = f; mp[c] = 1'b1;
         end
         m_err = v && (c >= NCHAN);
      end
      cyc++;
   endtask

   task automatic step(input logic r, input logic v, input logic [3:0] c, input logic [47:0] f);
      rst = r; req_valid = v; req_chan = c; req_freq = f;
      @(negedge cpu_clk);
      cycle_check(r, v, c, f);
      @(posedge cpu_clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 48'd0);
   endtask

   // Run idle cycles until n issues were observed, bounded.
   task automatic drain(input int n);
      int budget;
      budget = 0;
      while (issued.size() < n && budget < 80) begin idle(1); budget++; end
      chk("drain_timeout", 64'(issued.size() >= n), 64'(1));
      idle(2);
   endtask

   typedef struct packed {
      logic        v;
      logic [3:0]  c;
      logic [47:0] f;
      logic [4:0]  e_strb;   // {set_chan, freeze, freqH, freqL, busy}
      logic [31:0] e_tos;
      logic [7:0]  e_pend;
      logic        e_err;
   } vec_t;

   vec_t vecs [16];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [47:0] fa, fb, fc, fx, fe, fd;
      int nl;
      // Directed single issue on ch3, then out-of-range requests.
      vecs[0]  = '{1'b1, 4'd3,  48'h0012_3456_789A, 5'b00000, 32'h0,        8'h00, 1'b0};
      vecs[1]  = '{1'b0, 4'd0,  48'h0,              5'b00000, 32'h0,        8'h08, 1'b0};
      vecs[2]  = '{1'b0, 4'd0,  48'h0,              5'b10001, 32'h3,        8'h00, 1'b0};
      vecs[3]  = '{1'b0, 4'd0,  48'h0,              5'b01001, 32'h12,       8'h00, 1'b0};
      vecs[4]  = '{1'b0, 4'd0,  48'h0,              5'b00001, 32'h12,       8'h00, 1'b0};
      vecs[5]  = '{1'b0, 4'd0,  48'h0,              5'b00001, 32'h12,       8'h00, 1'b0};
      vecs[6]  = '{1'b0, 4'd0,  48'h0,              5'b00101, 32'h12,       8'h00, 1'b0};
      vecs[7]  = '{1'b0, 4'd0,  48'h0,              5'b01001, 32'h3456789A, 8'h00, 1'b0};
      vecs[8]  = '{1'b0, 4'd0,  48'h0,              5'b00001, 32'h3456789A, 8'h00, 1'b0};
      vecs[9]  = '{1'b0, 4'd0,  48'h0,              5'b00001, 32'h3456789A, 8'h00, 1'b0};
      vecs[10] = '{1'b0, 4'd0,  48'h0,              5'b00011, 32'h3456789A, 8'h00, 1'b0};
      vecs[11] = '{1'b0, 4'd0,  48'h0,              5'b00000, 32'h3456789A, 8'h00, 1'b0};
      vecs[12] = '{1'b1, 4'd8,  48'hAAAA_BBBB_CCCC, 5'b00000, 32'h3456789A, 8'h00, 1'b0};
      vecs[13] = '{1'b1, 4'd15, 48'h1111_2222_3333, 5'b00000, 32'h3456789A, 8'h00, 1'b1};
      vecs[14] = '{1'b0, 4'd0,  48'h0,              5'b00000, 32'h3456789A, 8'h00, 1'b1};
      vecs[15] = '{1'b0, 4'd0,  48'h0,              5'b00000, 32'h3456789A, 8'h00, 1'b0};

      rst = 1'b1; req_valid = 1'b0; req_chan = '0; req_freq = '0;
      @(posedge cpu_clk); #1;
      step(1'b1, 1'b0, 4'd0, 48'd0);
      step(1'b1, 1'b0, 4'd0, 48'd0);

      for (int i = 0; i < 16; i++) begin
         step(1'b0, vecs[i].v, vecs[i].c, vecs[i].f);
         chk($sformatf("vec%0d_strobes", i), 64'({s_chan, s_frz, s_h, s_l, s_busy}), 64'(vecs[i].e_strb));
         chk($sformatf("vec%0d_tos", i),     64'(s_tos),  64'(vecs[i].e_tos));
         chk($sformatf("vec%0d_pending", i), 64'(s_pend), 64'(vecs[i].e_pend));
         chk($sformatf("vec%0d_req_err", i), 64'(s_err),  64'(vecs[i].e_err));
      end

      // Burst to ch1, ch5, ch2 from a fresh pointer: issue order 1, 2, 5, 10 cycles apart.
      step(1'b1, 1'b0, 4'd0, 48'd0);
      issued.delete();
      step(1'b0, 1'b1, 4'd1, 48'h0001_1111_1111);
      step(1'b0, 1'b1, 4'd5, 48'h0005_5555_5555);
      step(1'b0, 1'b1, 4'd2, 48'h0002_2222_2222);
      drain(3);
      if (issued.size() >= 3) begin
         chk("burst_order0", 64'(issued[0].chan), 64'(1));
         chk("burst_order1", 64'(issued[1].chan), 64'(2));
         chk("burst_order2", 64'(issued[2].chan), 64'(5));
         chk("burst_gap01",  64'(issued[1].at - issued[0].at), 64'(10));
         chk("burst_gap12",  64'(issued[2].at - issued[1].at), 64'(10));
         chk("burst_word2",  64'({issued[2].h[15:0], issued[2].l}), 64'(48'h0005_5555_5555));
      end

      // Three words to ch4 while ch0 is in flight: only the last one goes out.
      step(1'b1, 1'b0, 4'd0, 48'd0);
      issued.delete();
      fx = 48'h00AB_0000_0001; fa = 48'h0A0A_0000_000A; fb = 48'h0B0B_0000_000B; fc = 48'h0C0C_0000_000C;
      step(1'b0, 1'b1, 4'd0, fx);
      idle(2);
      step(1'b0, 1'b1, 4'd4, fa);
      step(1'b0, 1'b1, 4'd4, fb);
      step(1'b0, 1'b1, 4'd4, fc);
      drain(2);
      chk("coalesce_count", 64'(issued.size()), 64'(2));
      if (issued.size() >= 2) begin
         chk("coalesce_first", 64'({issued[0].h[15:0], issued[0].l}), 64'(fx));
         chk("coalesce_last",  64'({issued[1].h[15:0], issued[1].l}), 64'(fc));
         chk("coalesce_chan",  64'(issued[1].chan), 64'(4));
      end
`ifdef RX_FREQ_SCHED_STATS_EN
      chk("coalesce_cnt_total", 64'(coalesce_cnt), 64'(2));
`endif

      // Re-request of the in-flight channel: old word finishes, new word follows.
      step(1'b1, 1'b0, 4'd0, 48'd0);
      issued.delete();
      fe = 48'h0066_EEEE_EEEE; fd = 48'h0066_DDDD_DDDD;
      step(1'b0, 1'b1, 4'd6, fe);
      idle(3);
      step(1'b0, 1'b1, 4'd6, fd);
      drain(2);
      if (issued.size() >= 2) begin
         chk("inflight_old", 64'({issued[0].h[15:0], issued[0].l}), 64'(fe));
         chk("inflight_new", 64'({issued[1].h[15:0], issued[1].l}), 64'(fd));
      end

      // Reset on the FREQ_H write cycle aborts the sequence and drops pending work.
      step(1'b1, 1'b0, 4'd0, 48'd0);
      step(1'b0, 1'b1, 4'd2, 48'h0022_1234_5678);   // grant next cycle
      step(1'b0, 1'b1, 4'd5, 48'h0055_1234_5678);   // grant cycle
      idle(4);
      step(1'b1, 1'b0, 4'd0, 48'd0);                // WR_H cycle
      chk("abort_on_wr_h", 64'(s_h), 64'(1));
      idle(1);
      chk("abort_strobes", 64'({s_chan, s_frz, s_h, s_l}), 64'(0));
      chk("abort_busy",    64'(s_busy), 64'(0));
      chk("abort_pending", 64'(s_pend), 64'(0));
      nl = 0;
      for (int i = 0; i < 20; i++) begin idle(1); if (s_l === 1'b1) nl++; end
      chk("abort_no_freqL", 64'(nl), 64'(0));

      // Random traffic, occasional invalid channels and resets, against the reference.
      for (int i = 0; i < 3000; i++) begin
         logic r, v;
         logic [3:0] c;
         r = ($urandom_range(0, 399) == 0);
         v = ($urandom_range(0, 2) == 0);
         c = 4'($urandom_range(0, 9));
         step(r, v, c, {16'($urandom), 32'($urandom)});
      end
      idle(3 * LEN * NCHAN);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
